// File: rtl/parking_pkg.sv
// Shared definitions for the parking-lot controller.
//   SLOTS / SLOT_W : slot count and slot index width
//   FREE_W         : width of the free-slot counter (must hold 0..SLOTS)
//   state_e        : controller FSM states
//   count_free()   : number of zero bits in an occupancy vector
package parking_pkg;

    localparam int unsigned SLOTS  = 8;
    localparam int unsigned SLOT_W = 3;
    localparam int unsigned FREE_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_IN  = 2'd1,
        GATE_OUT = 2'd2
    } state_e;

    function automatic logic [FREE_W-1:0] count_free(input logic [SLOTS-1:0] occ);
        logic [FREE_W-1:0] n;
        n = '0;
        for (int i = 0; i < SLOTS; i++) begin
            n = n + {{(FREE_W-1){1'b0}}, ~occ[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/parking_controller_if.sv
// Request/response bundle between the lot sensors/gates and the controller.
//   master : drives requests, exit token and pattern writes (lot side)
//   slave  : controller side, drives pulses, token, gates and status
interface parking_controller_if;
    import parking_pkg::*;

    logic              pattern_we;
    logic [SLOT_W-1:0] pattern_in;
    logic              entry_req;
    logic              exit_req;
    logic [SLOT_W-1:0] exit_token;
    logic              entry_ack;
    logic              entry_rej;
    logic [SLOT_W-1:0] token;
    logic              exit_ack;
    logic              exit_err;
    logic              gate_in_open;
    logic              gate_out_open;
    logic [SLOTS-1:0]  occupancy;
    logic [FREE_W-1:0] free_count;
    logic              full;
    logic              busy;

    modport master (
        output pattern_we, pattern_in, entry_req, exit_req, exit_token,
        input  entry_ack, entry_rej, token, exit_ack, exit_err, gate_in_open,
               gate_out_open, occupancy, free_count, full, busy
    );

    modport slave (
        input  pattern_we, pattern_in, entry_req, exit_req, exit_token,
        output entry_ack, entry_rej, token, exit_ack, exit_err, gate_in_open,
               gate_out_open, occupancy, free_count, full, busy
    );

endinterface

// File: rtl/free_slot_finder.sv
// Lowest-zero priority encoder over the occupancy vector.
//   i_occ       : bit i = slot i occupied
//   o_slot      : index of the lowest free slot (0 when none free)
//   o_none_free : all slots occupied
module free_slot_finder
    import parking_pkg::*;
(
    input  logic [SLOTS-1:0]  i_occ,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_none_free
);

    always_comb begin
        o_slot = '0;
        // Scan downward so the lowest free index is the last one written.
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!i_occ[i]) begin
                o_slot = SLOT_W'(i);
            end
        end
    end

    assign o_none_free = &i_occ;

endmodule

// File: rtl/token_production.sv
// Token XOR block: o_y = i_a ^ i_pattern. XOR is its own inverse, so the same
// block encodes slot -> token and decodes token -> slot.
//   i_a       : slot index or token
//   i_pattern : current token pattern
//   o_y       : token or slot index
module token_production
    import parking_pkg::*;
(
    input  logic [SLOT_W-1:0] i_a,
    input  logic [SLOT_W-1:0] i_pattern,
    output logic [SLOT_W-1:0] o_y
);

    assign o_y = i_a ^ i_pattern;

endmodule

// File: rtl/parking_controller.sv
// Parking-lot sequencing controller.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of parking_controller_if (requests in; pulses,
//                token, gate drives, occupancy/free_count/full/busy out)
// Exit requests win over entry because an exit frees a slot. A grant opens
// the matching gate for GATE_CYCLES cycles, during which requests are ignored.
module parking_controller
    import parking_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parking_controller_if.slave  bus
);

    localparam logic [3:0] CntLoad = 4'(GATE_CYCLES - 1);

    state_e            r_state,     w_state_nxt;
    logic [3:0]        r_cnt,       w_cnt_nxt;
    logic [SLOTS-1:0]  r_occ,       w_occ_nxt;
    logic [FREE_W-1:0] r_free;
    logic              r_full;
    logic [SLOT_W-1:0] r_pattern;
    logic [SLOT_W-1:0] r_token,     w_token_nxt;
    logic              r_entry_ack, w_entry_ack_nxt;
    logic              r_entry_rej, w_entry_rej_nxt;
    logic              r_exit_ack,  w_exit_ack_nxt;
    logic              r_exit_err,  w_exit_err_nxt;

    logic [SLOT_W-1:0] w_free_slot;
    logic              w_none_free;
    logic [SLOT_W-1:0] w_entry_token;
    logic [SLOT_W-1:0] w_exit_slot;

    free_slot_finder u_finder (
        .i_occ       (r_occ),
        .o_slot      (w_free_slot),
        .o_none_free (w_none_free)
    );

    token_production u_encode (
        .i_a       (w_free_slot),
        .i_pattern (r_pattern),
        .o_y       (w_entry_token)
    );

    token_production u_decode (
        .i_a       (bus.exit_token),
        .i_pattern (r_pattern),
        .o_y       (w_exit_slot)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_occ_nxt       = r_occ;
        w_token_nxt     = r_token;
        w_entry_ack_nxt = 1'b0;
        w_entry_rej_nxt = 1'b0;
        w_exit_ack_nxt  = 1'b0;
        w_exit_err_nxt  = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (bus.exit_req) begin
                    if (r_occ[w_exit_slot]) begin
                        w_occ_nxt[w_exit_slot] = 1'b0;
                        w_exit_ack_nxt         = 1'b1;
                        w_cnt_nxt              = CntLoad;
                        w_state_nxt            = GATE_OUT;
                    end else begin
                        w_exit_err_nxt = 1'b1;
                    end
                end else if (bus.entry_req) begin
                    if (!w_none_free) begin
                        w_occ_nxt[w_free_slot] = 1'b1;
                        w_token_nxt            = w_entry_token;
                        w_entry_ack_nxt        = 1'b1;
                        w_cnt_nxt              = CntLoad;
                        w_state_nxt            = GATE_IN;
                    end else begin
                        w_entry_rej_nxt = 1'b1;
                    end
                end
            end
            GATE_IN, GATE_OUT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_occ       <= '0;
            r_free      <= FREE_W'(SLOTS);
            r_full      <= 1'b0;
            r_pattern   <= '0;
            r_token     <= '0;
            r_entry_ack <= 1'b0;
            r_entry_rej <= 1'b0;
            r_exit_ack  <= 1'b0;
            r_exit_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_occ       <= w_occ_nxt;
            // Status is derived from the next occupancy so it never lags it.
            r_free      <= count_free(w_occ_nxt);
            r_full      <= &w_occ_nxt;
            r_token     <= w_token_nxt;
            r_entry_ack <= w_entry_ack_nxt;
            r_entry_rej <= w_entry_rej_nxt;
            r_exit_ack  <= w_exit_ack_nxt;
            r_exit_err  <= w_exit_err_nxt;
            // Pattern only changes with an empty lot so no issued token goes stale.
            if (bus.pattern_we && (r_occ == '0)) begin
                r_pattern <= bus.pattern_in;
            end
        end
    end

    assign bus.entry_ack     = r_entry_ack;
    assign bus.entry_rej     = r_entry_rej;
    assign bus.exit_ack      = r_exit_ack;
    assign bus.exit_err      = r_exit_err;
    assign bus.token         = r_token;
    assign bus.gate_in_open  = (r_state == GATE_IN);
    assign bus.gate_out_open = (r_state == GATE_OUT);
    assign bus.occupancy     = r_occ;
    assign bus.free_count    = r_free;
    assign bus.full          = r_full;
    assign bus.busy          = (r_state != IDLE);

endmodule

// File: tb/tb_parking_controller.sv
// Directed bench for parking_controller: a vector table of single requests
// followed by hand-written sequences for simultaneous requests and mid-gate reset.
module tb_parking_controller;

    localparam int unsigned G = 4;

    typedef enum logic [1:0] {OpPat, OpEntry, OpExit} op_e;

    typedef struct {
        op_e        op;
        logic [2:0] din;        // pattern_in or exit_token
        logic [3:0] exp_pulse;  // {entry_ack, entry_rej, exit_ack, exit_err}
        logic [2:0] exp_tok;
        logic [7:0] exp_occ;
        logic [3:0] exp_free;
        logic       exp_full;
    } vec_t;

    localparam logic [3:0] PNone = 4'b0000;
    localparam logic [3:0] PEAck = 4'b1000;
    localparam logic [3:0] PERej = 4'b0100;
    localparam logic [3:0] PXAck = 4'b0010;
    localparam logic [3:0] PXErr = 4'b0001;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    parking_controller_if bus ();

    parking_controller #(.GATE_CYCLES(G)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] pulses();
        return {bus.entry_ack, bus.entry_rej, bus.exit_ack, bus.exit_err};
    endfunction

    function automatic vec_t mk(input op_e op, input logic [2:0] din, input logic [3:0] p,
                                input logic [2:0] t, input logic [7:0] o,
                                input logic [3:0] f, input logic fu);
        vec_t v;
        v.op = op; v.din = din; v.exp_pulse = p; v.exp_tok = t;
        v.exp_occ = o; v.exp_free = f; v.exp_full = fu;
        return v;
    endfunction

    // Called #1 after the grant edge; counts cycles the gate stays open (bounded).
    task automatic measure_gate(input string name, input bit is_in);
        int n;
        n = 0;
        while (((is_in ? bus.gate_in_open : bus.gate_out_open) === 1'b1) && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        check({name, "_gate_cycles"}, n, G);
        check({name, "_idle_after"}, bus.busy, 1'b0);
    endtask

    task automatic check_status(input string name, input vec_t v);
        check({name, "_token"}, bus.token, v.exp_tok);
        check({name, "_occ"}, bus.occupancy, v.exp_occ);
        check({name, "_free"}, bus.free_count, v.exp_free);
        check({name, "_full"}, bus.full, v.exp_full);
    endtask

    task automatic apply(input string name, input vec_t v);
        if (v.op == OpPat) begin
            bus.pattern_we = 1'b1;
            bus.pattern_in = v.din;
        end else if (v.op == OpEntry) begin
            bus.entry_req = 1'b1;
        end else begin
            bus.exit_req   = 1'b1;
            bus.exit_token = v.din;
        end
        @(posedge clk); #1;
        bus.pattern_we = 1'b0;
        bus.entry_req  = 1'b0;
        bus.exit_req   = 1'b0;
        check({name, "_pulse"}, pulses(), v.exp_pulse);
        check_status(name, v);
        if (v.exp_pulse == PEAck) begin
            measure_gate(name, 1'b1);
        end else if (v.exp_pulse == PXAck) begin
            measure_gate(name, 1'b0);
        end else begin
            check({name, "_no_gate"}, {bus.gate_in_open, bus.gate_out_open, bus.busy}, 3'b000);
        end
    endtask

    vec_t vecs[$];

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n          = 1'b0;
        bus.pattern_we = 1'b0;
        bus.pattern_in = 3'b000;
        bus.entry_req  = 1'b0;
        bus.exit_req   = 1'b0;
        bus.exit_token = 3'b000;

        // pattern 101: slot s gets token s^101
        vecs.push_back(mk(OpPat,   3'b101, PNone, 3'b000, 8'h00, 4'd8, 1'b0));
        vecs.push_back(mk(OpEntry, 3'b000, PEAck, 3'b101, 8'h01, 4'd7, 1'b0));
        vecs.push_back(mk(OpEntry, 3'b000, PEAck, 3'b100, 8'h03, 4'd6, 1'b0));
        vecs.push_back(mk(OpPat,   3'b011, PNone, 3'b100, 8'h03, 4'd6, 1'b0)); // ignored
        vecs.push_back(mk(OpExit,  3'b101, PXAck, 3'b100, 8'h02, 4'd7, 1'b0)); // slot 0
        vecs.push_back(mk(OpEntry, 3'b000, PEAck, 3'b101, 8'h03, 4'd6, 1'b0)); // reuse 0
        vecs.push_back(mk(OpExit,  3'b110, PXErr, 3'b101, 8'h03, 4'd6, 1'b0)); // slot 3 empty
        vecs.push_back(mk(OpEntry, 3'b000, PEAck, 3'b111, 8'h07, 4'd5, 1'b0));
        vecs.push_back(mk(OpEntry, 3'b000, PEAck, 3'b110, 8'h0F, 4'd4, 1'b0));
        vecs.push_back(mk(OpEntry, 3'b000, PEAck, 3'b001, 8'h1F, 4'd3, 1'b0));
        vecs.push_back(mk(OpEntry, 3'b000, PEAck, 3'b000, 8'h3F, 4'd2, 1'b0));
        vecs.push_back(mk(OpEntry, 3'b000, PEAck, 3'b011, 8'h7F, 4'd1, 1'b0));
        vecs.push_back(mk(OpEntry, 3'b000, PEAck, 3'b010, 8'hFF, 4'd0, 1'b1));
        vecs.push_back(mk(OpEntry, 3'b000, PERej, 3'b010, 8'hFF, 4'd0, 1'b1)); // full
        vecs.push_back(mk(OpExit,  3'b111, PXAck, 3'b010, 8'hFB, 4'd1, 1'b0)); // slot 2
        vecs.push_back(mk(OpEntry, 3'b000, PEAck, 3'b111, 8'hFF, 4'd0, 1'b1));

        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_pulse", pulses(), PNone);
        check("reset_status", {bus.token, bus.occupancy, bus.free_count, bus.full},
              {3'b000, 8'h00, 4'd8, 1'b0});
        check("reset_gates", {bus.gate_in_open, bus.gate_out_open, bus.busy}, 3'b000);

        foreach (vecs[i]) begin
            apply($sformatf("v%0d", i), vecs[i]);
        end

        // Exit and entry together while full: exit first, entry after the gate closes.
        bus.exit_req   = 1'b1;
        bus.exit_token = 3'b001;   // slot 4
        bus.entry_req  = 1'b1;
        @(posedge clk); #1;
        bus.exit_req = 1'b0;
        check("both_pulse", pulses(), PXAck);
        check("both_gate_out", bus.gate_out_open, 1'b1);
        check("both_occ", bus.occupancy, 8'hEF);
        measure_gate("both_exit", 1'b0);
        @(posedge clk); #1;
        bus.entry_req = 1'b0;
        check("both_entry_pulse", pulses(), PEAck);
        check("both_entry_token", bus.token, 3'b001);
        check("both_entry_occ", {bus.occupancy, bus.free_count, bus.full}, {8'hFF, 4'd0, 1'b1});
        measure_gate("both_entry", 1'b1);

        // Free slot 4 again, then reset in the middle of the entry gate.
        apply("pre_rst_exit", mk(OpExit, 3'b001, PXAck, 3'b001, 8'hEF, 4'd1, 1'b0));
        bus.entry_req = 1'b1;
        @(posedge clk); #1;
        bus.entry_req = 1'b0;
        check("rst_entry_pulse", pulses(), PEAck);
        @(posedge clk); #1;
        check("rst_gate_before", bus.gate_in_open, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_gate_async", {bus.gate_in_open, bus.busy}, 2'b00);
        check("rst_occ_async", bus.occupancy, 8'h00);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_status", {bus.occupancy, bus.free_count, bus.full}, {8'h00, 4'd8, 1'b0});

        // Pattern is back to 000 after reset: slot 0 gets token 000.
        apply("post_rst_entry", mk(OpEntry, 3'b000, PEAck, 3'b000, 8'h01, 4'd7, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/parking_controller.md
# parking_controller

Sequencing controller for the parking-lot token datapath. Tracks occupancy of 8 parking slots and grants entry by allocating the lowest free slot. Issues the entry token as slot XOR pattern and validates exit tokens by the inverse XOR. Drives the entry and exit gates for a fixed hold time and owns the programmable 3-bit pattern register.

## Interface
Parameters:
- GATE_CYCLES, 4, cycles a gate stays open after a grant; legal range 2..15

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- pattern_we  in  1  request to load pattern_in
- pattern_in  in  3  new token pattern
- entry_req  in  1  car at entry; level, held until entry_ack or entry_rej
- exit_req  in  1  car at exit; level, held until exit_ack or exit_err
- exit_token  in  3  token presented at exit; valid while exit_req=1
- entry_ack  out  1  one-cycle pulse: slot granted
- entry_rej  out  1  one-cycle pulse: lot full
- token  out  3  issued token; valid in the entry_ack cycle, holds value until next grant
- exit_ack  out  1  one-cycle pulse: token valid, slot freed
- exit_err  out  1  one-cycle pulse: token maps to an empty slot
- gate_in_open  out  1  entry gate drive
- gate_out_open  out  1  exit gate drive
- occupancy  out  8  bit i = slot i occupied
- free_count  out  4  number of free slots, 0..8
- full  out  1  occupancy == 8'hFF
- busy  out  1  FSM not in IDLE

## Operation
- Reset values: state IDLE; occupancy 8'h00; free_count 8; pattern 3'b000; token 3'b000; all pulses and gate outputs 0; full 0; busy 0.
- FSM states: IDLE, GATE_IN, GATE_OUT. Gate counter is 4 bits.
- In IDLE, requests are evaluated on each rising edge. Priority is exit over entry, because an exit frees a slot.
- Exit handling:
  - slot = exit_token ^ pattern.
  - If occupancy[slot]=1: clear the bit, pulse exit_ack, load counter with GATE_CYCLES-1, go to GATE_OUT.
  - Otherwise: pulse exit_err, stay in IDLE, leave occupancy unchanged.
- Entry handling (only when exit_req=0):
  - If not full: slot = lowest-index zero bit of occupancy. Set the bit, register token = slot ^ pattern, pulse entry_ack, load counter, go to GATE_IN.
  - If full: pulse entry_rej, stay in IDLE.
- GATE_IN / GATE_OUT:
  - The matching gate output is 1.
  - The counter decrements every cycle. At 0 the FSM returns to IDLE.
  - All requests are ignored in these states.
- After exit_err or entry_rej, IDLE re-samples on the next edge. The requester must drop req in the cycle after the pulse, or it receives another pulse.
- Pattern write:
  - Accepted on any edge where pattern_we=1 and occupancy=0. Takes effect for requests evaluated on the following edge.
  - Ignored while any slot is occupied, so that outstanding tokens are never invalidated.
  - May coincide with a request. The request uses the old pattern.
- free_count and full are registered together with occupancy and are always consistent with it.

## Timing
- Request high before edge k (FSM in IDLE): the response pulse is high during cycle k→k+1. Occupancy and token update at edge k.
- Gate output is high for exactly GATE_CYCLES cycles starting at edge k. The FSM is back in IDLE at edge k+GATE_CYCLES, and the earliest next request is sampled at edge k+GATE_CYCLES+1.
- Requesters must deassert req within GATE_CYCLES cycles after an ack, otherwise the same request is re-served.
- Reset asserted mid-gate: gates close immediately (asynchronous) and all occupancy is lost. This is intentional: the lot is re-counted after reset.

## Structure
- Shared package parking_pkg holds:
  - constants SLOTS=8 and SLOT_W=3
  - the state enum {IDLE, GATE_IN, GATE_OUT}
- One natural new sub-module, free_slot_finder: an 8-bit lowest-zero priority encoder with outputs slot[2:0] and none_free.
- Token encode and decode reuse the existing token_production XOR block, two instances:
  - slot → token
  - exit_token → slot

## Test plan
- Reset, then pattern_we with pattern_in=3'b101. Two entries → tokens 3'b101 (slot 0) then 3'b100 (slot 1); occupancy=8'h03; free_count=6; gate_in_open high 4 cycles each.
- Exit with token 3'b101 → exit_ack; occupancy=8'h02. Next entry reuses slot 0 and is issued token 3'b101.
- Eight entries → full=1 and occupancy=8'hFF. Ninth entry → entry_rej with no state change. Then a valid exit followed by an entry is granted.
- Exit with a token mapping to an empty slot → exit_err; occupancy unchanged; gate_out_open stays 0.
- exit_req and entry_req both high while full → exit served first (exit_ack, gate_out_open). Entry is granted once back in IDLE, taking the freed slot.
- pattern_we with pattern_in=3'b011 while occupancy≠0 → pattern unchanged. Assert rst_n=0 during GATE_IN → gate_in_open falls immediately; occupancy=0 and free_count=8 after release.
